// File: rtl/countdown_pkg.sv
// countdown_pkg: state encoding, digit limits and defaults shared by the countdown timer
package countdown_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_e;
   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;
   localparam int TICK_DIV_DEF = 500000;
   localparam int BLINK_TICKS = 5;
   function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit with load, wrap-to-limit and borrow out
module bcd_down_digit (
   input  logic       clk_main,
   input  logic       reset,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic [3:0] limit_i,
   input  logic       borrow_i,
   output logic [3:0] digit_o,
   output logic       borrow_o
);
   logic [3:0] digit_q, digit_d;
   // load wins over decrement; a decrement from zero wraps to the limit and borrows
   always_comb digit_d = load_i ? load_val_i : borrow_i ? ((digit_q == 4'd0) ? limit_i : digit_q - 4'd1) : digit_q;
   // digit register
   always_ff @(posedge clk_main or negedge reset)
      if (!reset) digit_q <= '0;
      else digit_q <= digit_d;
   assign digit_o = digit_q;
   assign borrow_o = borrow_i && (digit_q == 4'd0);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: M:SS.t countdown with run/pause/clear/load; ALARM_BLINK_EN enables a 0.5 s blinking alarm
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int CNT_W = 19
) (
   input  logic       clk_main,
   input  logic       reset,
   input  logic       start,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] preset_min,
   input  logic [3:0] preset_10s,
   input  logic [3:0] preset_1s,
   output logic [3:0] digit_1min,
   output logic [3:0] digit_10sec,
   output logic [3:0] digit_1sec,
   output logic [3:0] digit_1_10sec,
   output logic       running,
   output logic       expired,
   output logic       alarm
);
   state_e state_q, state_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic [15:0] preset_q, preset_d, preset_in, load_val, cnt;
   logic [3:0] dig [4];
   logic [4:0] brw;
   logic presc_end, tick, load_eff, start_eff, load_en;
   assign presc_end = presc_q == CNT_W'(TICK_DIV - 1);
   assign tick = (state_q == S_RUN) && presc_end;
   assign load_eff = load && !clear && (state_q != S_RUN);
   assign start_eff = start && !clear && !load;
   assign load_en = clear || load_eff;
   assign preset_in = {clamp(preset_min, DIGIT_MAX), clamp(preset_10s, TENS_MAX), clamp(preset_1s, DIGIT_MAX), 4'd0};
   assign load_val = !load_en ? '0 : clear ? preset_q : preset_in;
   assign preset_d = load_eff ? preset_in : preset_q;
   assign cnt = {dig[3], dig[2], dig[1], dig[0]};
   assign brw[0] = tick;
   // tenths, seconds, tens, minutes; an underflow out of the minutes pins the count at zero
   for (genvar i = 0; i < 4; i++) begin : g_dig
      bcd_down_digit u_dig (
         .clk_main  (clk_main),
         .reset     (reset),
         .load_i    (load_en || brw[4]),
         .load_val_i(load_val[4*i +: 4]),
         .limit_i   ((i == 2) ? TENS_MAX : DIGIT_MAX),
         .borrow_i  (brw[i]),
         .digit_o   (dig[i]),
         .borrow_o  (brw[i+1])
      );
   end
   assign digit_1_10sec = dig[0];
   assign digit_1sec = dig[1];
   assign digit_10sec = dig[2];
   assign digit_1min = dig[3];
   // state, prescaler and preset registers
   always_ff @(posedge clk_main or negedge reset)
      if (!reset) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         preset_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         preset_q <= preset_d;
      end
   // next state: clear > load > start; the final tick beats a simultaneous start
   always_comb begin
      state_d = state_q;
      if (load_en) state_d = S_IDLE;
      else
         case (state_q)
            S_IDLE:  state_d = (start_eff && cnt != '0) ? S_RUN : S_IDLE;
            S_RUN:   state_d = (tick && cnt == 16'h0001) ? S_EXPIRED : start_eff ? S_PAUSE : S_RUN;
            S_PAUSE: state_d = start_eff ? S_RUN : S_PAUSE;
            default: state_d = state_q;
         endcase
   end
   // prescaler free-runs in RUN and EXPIRED, holds in PAUSE, rests at zero in IDLE
   always_comb presc_d = (load_en || state_q == S_IDLE) ? '0 : (state_q == S_PAUSE) ? presc_q : presc_end ? '0 : presc_q + CNT_W'(1);
   // Moore status outputs
   always_comb begin
      running = state_q == S_RUN;
      expired = state_q == S_EXPIRED;
   end
`ifdef ALARM_BLINK_EN
   logic alarm_q, alarm_d, blink_tick, blink_end;
   logic [2:0] blink_q, blink_d;
   assign blink_tick = (state_q == S_EXPIRED) && presc_end;
   assign blink_end = blink_tick && (blink_q == 3'(BLINK_TICKS - 1));
   // alarm starts high on entering EXPIRED and flips every BLINK_TICKS ticks while there
   always_comb begin
      blink_d = (state_d != S_EXPIRED || state_q != S_EXPIRED || blink_end) ? '0 : blink_tick ? blink_q + 3'd1 : blink_q;
      alarm_d = (state_d != S_EXPIRED) ? 1'b0 : (state_q != S_EXPIRED) ? 1'b1 : blink_end ? ~alarm_q : alarm_q;
   end
   // blink registers
   always_ff @(posedge clk_main or negedge reset)
      if (!reset) begin
         alarm_q <= 1'b0;
         blink_q <= '0;
      end else begin
         alarm_q <= alarm_d;
         blink_q <= blink_d;
      end
   assign alarm = alarm_q;
`else
   assign alarm = expired;
`endif
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clk_main cycles per 0.1 s tick (5 MHz clock).
REQ-002 SHALL have parameter CNT_W, default 19, prescaler width, satisfying 2**CNT_W >= TICK_DIV.
REQ-003 SHALL have port clk_main  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports start, clear, load  in  1 each  single-cycle debounced pulses; start toggles run/pause.
REQ-006 SHALL have ports preset_min, preset_10s, preset_1s  in  4 each  BCD preset value M:SS.
REQ-007 SHALL have ports digit_1min, digit_10sec, digit_1sec, digit_1_10sec  out  4 each  current BCD count.
REQ-008 SHALL have ports running, expired, alarm  out  1 each  status outputs for display and LED.

Function
REQ-009 SHALL implement states IDLE, RUN, PAUSE, EXPIRED; running=1 only in RUN; expired=1 only in EXPIRED.
REQ-010 load in IDLE, PAUSE or EXPIRED SHALL capture the presets into a preset register and the digits, set digit_1_10sec=0, and go to IDLE; load in RUN SHALL be ignored.
REQ-011 On load, any preset digit above 9 SHALL clamp to 9, and preset_10s above 5 SHALL clamp to 5.
REQ-012 clear in any state SHALL reload the digits from the preset register, zero the prescaler, and go to IDLE.
REQ-013 Same-cycle pulses SHALL be prioritised clear > load > start; lower-priority pulses in that cycle are dropped.
REQ-014 start SHALL cause these transitions: IDLE to RUN if count != 0:00.0, else stay in IDLE; RUN to PAUSE; PAUSE to RUN; ignored in EXPIRED.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 in RUN and EXPIRED, hold its value in PAUSE, and be zeroed on the IDLE to RUN transition.
REQ-016 In RUN, the edge at which the prescaler equals TICK_DIV-1 SHALL decrement the count by 0.1 s, with outputs updated on that edge.
REQ-017 Decrement SHALL borrow in this order: tenths 0 to 9 borrows from seconds; seconds 0 to 9 borrows from tens; tens 0 to 5 borrows from minutes.
REQ-018 A decrement that produces 0:00.0 SHALL move the state to EXPIRED on the same edge; the digits SHALL hold at 0 and never wrap to 9:59.9.
REQ-019 start on the same edge as the final tick SHALL be ignored; EXPIRED wins.
REQ-020 Digits SHALL always remain valid BCD within their limits (9, 5, 9, 9).

Reset
REQ-021 While reset=0, the block SHALL force state=IDLE, digits=0, preset register=0, prescaler=0, and running=expired=alarm=0, independent of clk_main.
REQ-022 reset asserted mid-RUN SHALL abort the count immediately; after deassertion, the block SHALL sit in IDLE until a load.

Configuration
REQ-023 With ALARM_BLINK_EN defined, alarm SHALL be 1 on EXPIRED entry and toggle every 5 ticks (0.5 s) while EXPIRED, and be 0 elsewhere.
REQ-024 With ALARM_BLINK_EN undefined, alarm SHALL equal expired, with no blink logic present.

Structure
REQ-025 Package countdown_pkg SHALL hold the state encoding, digit limit constants (9, 5), and the TICK_DIV default.
REQ-026 Sub-module bcd_down_digit (inputs: limit, borrow_in, load value; outputs: digit, borrow_out at zero) SHALL be instantiated four times in a borrow chain.

Verification (TICK_DIV=4)
REQ-027 load 1:00 then start, 4 cycles later -> count 0:59.9, running=1.
REQ-028 load 0:00.0 then start -> stays IDLE, running=0; load 0:00 with tenths at 0 and start -> no tick.
REQ-029 load 0:01 then run 10 ticks -> 0:00.0, expired=1 on the 10th tick edge; further ticks leave the digits at 0.
REQ-030 run 2 cycles, pause for 20 cycles, resume -> tick fires 2 cycles after resume (prescaler held).
REQ-031 clear, load and start asserted in the same cycle during RUN -> IDLE with the preset reloaded; load preset_10s=7 -> digit_10sec=5.
REQ-032 assert reset mid-RUN -> all outputs 0 asynchronously; with ALARM_BLINK_EN defined, alarm toggles at 5-tick intervals in EXPIRED.
